// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial link receiver and its transmitter counterpart.
package serial_rx_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_e;

    // Bit-counter width for an n-bit word, never narrower than one bit.
    function automatic int CNT_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver: assembles N-bit words MSB- or LSB-first and
// hands them to the consumer through a held output register with valid/ack.
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         shift_in,
    input  logic         shift_en,
    input  logic         msb_first,
    input  logic         ack,
    output logic [N-1:0] dout,
    output logic         valid,
    output logic         busy,
    output logic         overrun
);

    localparam int            CW   = CNT_W(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic [N-1:0]  shifted;
    logic          complete;
    logic          slot_free;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        shifted   = mode_q ? {sreg_q[N-2:0], shift_in} : {shift_in, sreg_q[N-1:1]};
        // start has priority over a bit presented in the same cycle.
        complete  = (state_q == S_RECV) && shift_en && !start && (cnt_q == LAST);
        slot_free = !valid_q || ack;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RECV;
                    mode_d  = msb_first;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_RECV: begin
                if (start) begin
                    mode_d = msb_first;
                    sreg_d = '0;
                    cnt_d  = '0;
                end else if (shift_en) begin
                    sreg_d = shifted;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completed word only lands if the consumer has drained the slot.
        if (complete) begin
            if (slot_free) begin
                dout_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign busy    = (state_q == S_RECV);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (N=8) with immediate-assertion checks.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       shift_in = 1'b0;
    logic       shift_en = 1'b0;
    logic       msb_first = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    serial_word_receiver #(.N(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .shift_in  (shift_in),
        .shift_en  (shift_en),
        .msb_first (msb_first),
        .ack       (ack),
        .dout      (dout),
        .valid     (valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        shift_en = 1'b1;
        shift_in = b;
        tick();
        shift_en = 1'b0;
        shift_in = 1'b0;
    endtask

    task automatic begin_frame(input logic m);
        start     = 1'b1;
        msb_first = m;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic m, input logic [7:0] w);
        begin_frame(m);
        for (int i = 0; i < 8; i++) send_bit(m ? w[7-i] : w[i]);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1010_0101;

        // Reset state
        #12;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        clr = 1'b0;
        tick();

        // MSB-first A5 with a gap mid-frame
        begin_frame(1'b1);
        check("msb_busy_after_start", busy, 1'b1);
        for (int i = 0; i < 7; i++) begin
            send_bit(pat[7-i]);
            if (i == 2) begin
                tick();
                tick();
            end
        end
        check("msb_valid_before_last", valid, 1'b0);
        check("msb_busy_before_last", busy, 1'b1);
        send_bit(pat[0]);
        check("msb_dout", dout, 8'hA5);
        check("msb_valid", valid, 1'b1);
        check("msb_busy_done", busy, 1'b0);
        do_ack();
        check("msb_ack_valid", valid, 1'b0);
        check("msb_ack_dout_held", dout, 8'hA5);

        // LSB-first palindrome A5
        send_word(1'b0, 8'hA5);
        check("lsb_dout_a5", dout, 8'hA5);
        check("lsb_valid_a5", valid, 1'b1);
        do_ack();

        // LSB-first 01, msb_first flipped mid-frame must not matter
        begin_frame(1'b0);
        send_bit(1'b1);
        msb_first = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        check("lsb_dout_01", dout, 8'h01);
        do_ack();
        check("ack_valid_clear", valid, 1'b0);
        do_ack();
        check("ack_idle_ignored", valid, 1'b0);

        // Overrun: 3C held, FF discarded
        send_word(1'b1, 8'h3C);
        check("ovr_first", dout, 8'h3C);
        send_word(1'b1, 8'hFF);
        check("ovr_dout_kept", dout, 8'h3C);
        check("ovr_valid", valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        do_ack();
        check("ovr_ack_valid", valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Asynchronous clear mid-frame
        begin_frame(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_dout", dout, 8'h00);
        check("clr_valid", valid, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_overrun", overrun, 1'b0);
        #1;
        clr = 1'b0;
        tick();
        send_word(1'b1, 8'h5A);
        check("post_clr_dout", dout, 8'h5A);
        check("post_clr_valid", valid, 1'b1);
        do_ack();

        // Ack coincident with completion
        send_word(1'b1, 8'h11);
        check("coinc_first", dout, 8'h11);
        begin_frame(1'b1);
        pat = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(pat[7-i]);
        ack = 1'b1;
        send_bit(pat[0]);
        ack = 1'b0;
        check("coinc_dout", dout, 8'h22);
        check("coinc_valid", valid, 1'b1);
        check("coinc_overrun", overrun, 1'b0);
        do_ack();

        // Restart after 4 bits; the restarting start carries a bit that must be ignored
        begin_frame(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        start     = 1'b1;
        msb_first = 1'b1;
        shift_en  = 1'b1;
        shift_in  = 1'b1;
        tick();
        start    = 1'b0;
        shift_en = 1'b0;
        shift_in = 1'b0;
        check("restart_busy", busy, 1'b1);
        check("restart_dout_kept", dout, 8'h22);
        check("restart_valid", valid, 1'b0);
        pat = 8'hC3;
        for (int i = 0; i < 7; i++) send_bit(pat[7-i]);
        check("restart_no_partial", valid, 1'b0);
        send_bit(pat[0]);
        check("restart_dout", dout, 8'hC3);
        check("restart_valid_done", valid, 1'b1);
        check("restart_busy_done", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
